// File: rtl/mux_pipe_n.sv
// N-way registered mux with a valid/ready handshake.
// The output stage holds a main entry plus one skid entry.
module mux_pipe_n #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              err_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_err;
  logic [WIDTH-1:0]   main_data, skid_data;
  logic               main_err, skid_err;
  logic               in_xfer, out_xfer;
  logic               load_main_new, load_main_skid, load_skid;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_err   = main_err;

  always_comb begin
    state_next     = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_next    = ONE;
          load_main_new = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_new = 1'b1;
        end else if (in_xfer) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      // Registered from the next state, so out_ready never reaches in_ready combinationally.
      in_ready <= (state_next != TWO);
    end
  end

  // NOTE: the two data entries are reset because out_data/out_err must read zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_main_new) begin
        main_data <= sel_data;
        main_err  <= sel_err;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_err  <= sel_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (in_xfer && sel_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: doc/mux_pipe_n.md
MUX_PIPE_N -- requirements
Module: mux_pipe_n

Interface
REQ-001 Parameter: WIDTH, default 5, data width of each input channel and of the output.
REQ-002 Parameter: NUM_IN, default 4, number of input channels, legal range 2..16.
REQ-003 Derived parameter: SEL_W = max(1, ceil(log2(NUM_IN))), width of the select field; not user-overridable.
REQ-004 Port: clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: in_data  input  NUM_IN*WIDTH  packed channels, channel k at bits [k*WIDTH +: WIDTH].
REQ-007 Port: in_sel  input  SEL_W  channel select, sampled with in_data.
REQ-008 Port: in_valid  input  1  upstream offers in_data/in_sel this cycle.
REQ-009 Port: in_ready  output  1  block accepts an offer this cycle.
REQ-010 Port: out_data  output  WIDTH  selected channel value.
REQ-011 Port: out_err  output  1  this out_data came from an out-of-range select.
REQ-012 Port: out_valid  output  1  out_data/out_err hold a valid result.
REQ-013 Port: out_ready  input  1  downstream accepts the result this cycle.
REQ-014 Port: err_cnt  output  8  saturating count of accepted out-of-range selects.

Function
REQ-015 Input transfer occurs on a rising edge where in_valid && in_ready; output transfer occurs on a rising edge where out_valid && out_ready.
REQ-016 Selection: result = channel in_sel when in_sel < NUM_IN; otherwise result = all-zero and its err flag = 1.
REQ-017 Latency: an accepted item appears on out_data exactly 1 cycle after acceptance when the output stage is empty or draining.
REQ-018 Storage: a main output register plus one skid register (data + err each), giving 2-entry capacity.
REQ-019 State machine: EMPTY (no entry), ONE (main valid), TWO (main and skid valid).
REQ-020 EMPTY: input transfer -> ONE; otherwise stay.
REQ-021 ONE: input transfer with no output transfer -> TWO (new item to skid); output transfer with no input transfer -> EMPTY; both -> stay ONE, new item to main; neither -> stay.
REQ-022 TWO: output transfer -> ONE, skid moves to main; in_ready = 0, so no input transfer is possible.
REQ-023 in_ready is a registered signal: in_ready = 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-024 out_valid = 1 in ONE and TWO; out_data/out_err are driven only from the main register.
REQ-025 While out_valid && !out_ready, out_data and out_err remain stable.
REQ-026 Ordering: items leave in acceptance order; none is dropped or duplicated.
REQ-027 err_cnt increments by 1 on each input transfer with in_sel >= NUM_IN and saturates at 255, with no wrap-around.
REQ-028 When NUM_IN is a power of two, no select is out of range: out_err is always 0 and err_cnt stays 0.
REQ-029 in_data and in_sel are ignored in cycles without an input transfer.

Reset
REQ-030 While rst = 1, regardless of clk: state = EMPTY, out_valid = 0, out_data = 0, out_err = 0, err_cnt = 0, in_ready = 1.
REQ-031 Reset asserted mid-operation discards both stored entries immediately; no partial transfer completes on that edge.
REQ-032 First input transfer is possible on the first rising edge after rst deasserts.

Verification (WIDTH=5, NUM_IN=4 unless noted)
REQ-033 Streaming: in_data = {5'd3,5'd2,5'd1,5'd0}, sel 0,1,2,3 on consecutive cycles with out_ready = 1 -> out_data 0,1,2,3 one cycle later each, in_ready held at 1, out_err = 0.
REQ-034 Backpressure: out_ready = 0, offer A = 7, B = 9, C = 11 -> A and B accepted, in_ready = 0 with C pending, out_data = 7 stable. Then out_ready = 1 -> outputs 7, 9, 11 in order, no loss.
REQ-035 Simultaneous: in ONE state, input and output transfer on the same edge -> state stays ONE and out_data = new item.
REQ-036 Out of range (NUM_IN=3, SEL_W=2): sel = 3 accepted -> out_data = 0, out_err = 1, err_cnt = 1. After 300 such transfers -> err_cnt = 255.
REQ-037 Reset mid-flight: TWO state, assert rst between clock edges -> out_valid = 0, in_ready = 1, and err_cnt = 0 at once. After release, the first offered item is output 1 cycle after acceptance.
